// File: rtl/noc_arb_pkg.sv
// Shared types and defaults for the NoC round-robin arbiter.
// The packet-lock feature is enabled by defining ARB_PKT_LOCK_EN.
package noc_arb_pkg;

  localparam int DEF_NUM_IN     = 5;
  localparam int DEF_WIDTH      = 3;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits for a single entry.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_arb_fifo.sv
// Per-input flit FIFO (payload plus last bit), no bypass path.
// Pointers carry one wrap bit so full and empty are distinguished without a counter.
module noc_arb_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/noc_rr_arbiter.sv
// N-input round-robin arbiter with per-input FIFOs and a registered output slot.
// Define ARB_PKT_LOCK_EN to hold the grant on one input until its tail flit.
module noc_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_IN     = DEF_NUM_IN,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int SW        = idx_width(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN-1:0][WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_last,
  output logic [NUM_IN-1:0]            in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_last,
  output logic [SW-1:0]                out_src,
  input  logic                         out_ready
);

  localparam logic [SW-1:0] LAST_IDX = SW'(NUM_IN - 1);
  localparam logic [SW-1:0] ONE_IDX  = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW:0]   NUM_W    = (SW+1)'(NUM_IN);

  logic [NUM_IN-1:0] push;
  logic [NUM_IN-1:0] pop;
  logic [NUM_IN-1:0] full;
  logic [NUM_IN-1:0] empty;
  logic [NUM_IN-1:0] elig;
  logic [WIDTH:0]    head [NUM_IN];

  logic              slot_free;
  logic              any_elig;
  logic              grant;
  logic              grant_last;
  logic              hit;
  logic [SW:0]       cand_wide;
  logic [SW-1:0]     cand;
  logic [SW-1:0]     pick;
  logic [SW-1:0]     pick_inc;
  logic [SW-1:0]     ptr;
  logic [SW-1:0]     ptr_next;

  assign in_ready = ~full;
  assign push     = in_valid & ~full;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_fifo
    noc_arb_fifo #(
      .DW    (WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[g]),
      .push_data ({in_last[g], in_data[g]}),
      .pop       (pop[g]),
      .full      (full[g]),
      .empty     (empty[g]),
      .head      (head[g])
    );
  end

`ifdef ARB_PKT_LOCK_EN
  arb_state_e    state;
  arb_state_e    state_next;
  logic [SW-1:0] lock_idx;
  logic [SW-1:0] lock_idx_next;

  // While locked only the owning input may compete.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      elig[i] = ~empty[i] & ((state == ARB_IDLE) | (lock_idx == SW'(i)));
    end
  end
`else
  // Every non-empty input competes.
  always_comb begin
    elig = ~empty;
  end
`endif

  assign slot_free = ~out_valid | out_ready;
  assign grant     = slot_free & any_elig;

  // First eligible input scanning ptr, ptr+1, ... modulo NUM_IN.
  always_comb begin
    pick      = '0;
    any_elig  = 1'b0;
    hit       = 1'b0;
    cand_wide = '0;
    cand      = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand_wide = {1'b0, ptr} + (SW+1)'(k);
      cand_wide = (cand_wide >= NUM_W) ? (cand_wide - NUM_W) : cand_wide;
      cand      = cand_wide[SW-1:0];
      hit       = ~any_elig & elig[cand];
      any_elig  = any_elig | hit;
      pick      = hit ? cand : pick;
    end
  end

  assign grant_last = head[pick][WIDTH];
  assign pick_inc   = (pick == LAST_IDX) ? '0 : (pick + ONE_IDX);

  // Pop strobe for the granted input.
  always_comb begin
    pop = '0;
    if (grant) begin
      pop[pick] = 1'b1;
    end else begin
      pop = '0;
    end
  end

  // Next pointer and lock state.
  always_comb begin
    ptr_next = ptr;
`ifdef ARB_PKT_LOCK_EN
    state_next    = state;
    lock_idx_next = lock_idx;
    if (grant) begin
      if (grant_last) begin
        state_next = ARB_IDLE;
        ptr_next   = pick_inc;
      end else begin
        state_next    = ARB_LOCKED;
        lock_idx_next = pick;
      end
    end else begin
      state_next = state;
    end
`else
    if (grant) begin
      ptr_next = pick_inc;
    end else begin
      ptr_next = ptr;
    end
`endif
  end

  // Round-robin pointer and lock registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
`ifdef ARB_PKT_LOCK_EN
      state    <= ARB_IDLE;
      lock_idx <= '0;
`endif
    end else begin
      ptr <= ptr_next;
`ifdef ARB_PKT_LOCK_EN
      state    <= state_next;
      lock_idx <= lock_idx_next;
`endif
    end
  end

  // Output slot: reload when free, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (slot_free) begin
      out_valid <= grant;
      if (grant) begin
        out_data <= head[pick][WIDTH-1:0];
        out_last <= grant_last;
        out_src  <= pick;
      end
    end
  end

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Self-checking bench for noc_rr_arbiter: vector table, directed corner sequences and
// random traffic against a queue-based reference model. Honours ARB_PKT_LOCK_EN.
module tb_noc_rr_arbiter;

  localparam int N = 5;
  localparam int W = 3;
  localparam int D = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        in_valid;
  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0]        in_last;
  logic [N-1:0]        in_ready;
  logic                out_valid;
  logic [W-1:0]        out_data;
  logic                out_last;
  logic [2:0]          out_src;
  logic                out_ready;

  int errors = 0;
  int checks = 0;

  noc_rr_arbiter #(.NUM_IN(N), .WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: per-input queues, output slot, pointer, lock.
  logic [W:0]   m_q [N][D];
  int           m_cnt [N];
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_last;
  int           m_src;
  int           m_ptr;
  bit           m_locked;
  int           m_lock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_valid = 1'b0; m_data = '0; m_last = 1'b0; m_src = 0;
    m_ptr = 0; m_locked = 1'b0; m_lock = 0;
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (m_cnt[i] < D);
    return r;
  endfunction

  task automatic model_edge();
    logic [N-1:0] rdy;
    int win;
    int c;
    rdy = model_ready();
    win = -1;
    if (!m_valid || out_ready) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (win < 0 && m_cnt[c] > 0 && (!m_locked || c == m_lock)) win = c;
      end
      if (win >= 0) begin
        m_valid = 1'b1;
        {m_last, m_data} = m_q[win][0];
        m_src = win;
        for (int j = 0; j < D - 1; j++) m_q[win][j] = m_q[win][j+1];
        m_cnt[win]--;
`ifdef ARB_PKT_LOCK_EN
        if (m_last) begin
          m_locked = 1'b0;
          m_ptr = (win + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_lock = win;
        end
`else
        m_ptr = (win + 1) % N;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && rdy[i]) begin
        m_q[i][m_cnt[i]] = {in_last[i], in_data[i]};
        m_cnt[i]++;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("model_valid", 32'(out_valid), 32'(m_valid));
    check("model_data", 32'(out_data), 32'(m_data));
    check("model_last", 32'(out_last), 32'(m_last));
    check("model_src", 32'(out_src), 32'(m_src));
    check("model_in_ready", 32'(in_ready), 32'(model_ready()));
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_data = '0; in_last = '0;
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'h1f);
    model_clear();
    idle_inputs();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]   vld;
    logic [N*W-1:0] dat;
    logic [N-1:0]   lst;
    logic           evld;
    logic [W-1:0]   edat;
    logic [2:0]     esrc;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ev,
                              input logic [W-1:0] ed, input logic [2:0] es);
    vec_t r;
    r.vld = v; r.dat = d; r.lst = v; r.evld = ev; r.edat = ed; r.esrc = es;
    return r;
  endfunction

  vec_t tbl [12];
  int   acc;
  logic [W-1:0] held;
  logic [4:0] lk_vld;
  logic [14:0] lk_src;

  initial begin
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle_inputs();
    model_clear();

    // Round-robin sweep from ptr=0, then single push on input 2, then ptr-order check.
    tbl[0]  = mk(5'b11111, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, 1'b0, 3'd0, 3'd0);
    tbl[1]  = mk(5'b00000, 15'd0, 1'b1, 3'd1, 3'd0);
    tbl[2]  = mk(5'b00000, 15'd0, 1'b1, 3'd2, 3'd1);
    tbl[3]  = mk(5'b00000, 15'd0, 1'b1, 3'd3, 3'd2);
    tbl[4]  = mk(5'b00000, 15'd0, 1'b1, 3'd4, 3'd3);
    tbl[5]  = mk(5'b00000, 15'd0, 1'b1, 3'd5, 3'd4);
    tbl[6]  = mk(5'b00100, {3'd0, 3'd0, 3'b101, 3'd0, 3'd0}, 1'b0, 3'd0, 3'd0);
    tbl[7]  = mk(5'b00000, 15'd0, 1'b1, 3'b101, 3'd2);
    tbl[8]  = mk(5'b01001, {3'd0, 3'b011, 3'd0, 3'd0, 3'b110}, 1'b0, 3'd0, 3'd0);
    tbl[9]  = mk(5'b00000, 15'd0, 1'b1, 3'b011, 3'd3);
    tbl[10] = mk(5'b00000, 15'd0, 1'b1, 3'b110, 3'd0);
    tbl[11] = mk(5'b00000, 15'd0, 1'b0, 3'd0, 3'd0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].vld;
      in_data  = tbl[i].dat;
      in_last  = tbl[i].lst;
      tick();
      check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].evld));
      if (tbl[i].evld) begin
        check($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].edat));
        check($sformatf("tbl%0d_src", i), 32'(out_src), 32'(tbl[i].esrc));
        check($sformatf("tbl%0d_last", i), 32'(out_last), 32'd1);
      end
    end

    // Backpressure: input 1 streams while out_ready is low.
    do_reset();
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 5'b00010;
      in_data[1] = W'(acc + 1);
      in_last[1] = 1'b1;
      if (in_ready[1]) acc++;
      tick();
      if (c == 1) check("bp_ready_after2", 32'(in_ready[1]), 32'd1);
      if (c >= 2) check("bp_ready_full", 32'(in_ready[1]), 32'd0);
      if (c >= 1) begin
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_data", 32'(out_data), 32'd1);
      end
    end
    check("bp_accepted", 32'(acc), 32'd3);
    idle_inputs();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_drain_valid", 32'(out_valid), (c < 2) ? 32'd1 : 32'd0);
      if (c < 2) check("bp_drain_data", 32'(out_data), 32'(c + 2));
    end

    // Input 0 sends a 3-flit packet with a gap; input 1 always valid.
    do_reset();
`ifdef ARB_PKT_LOCK_EN
    lk_vld = 5'b11011;
    lk_src = {3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
`else
    lk_vld = 5'b11111;
    lk_src = {3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
`endif
    held = 3'b111;
    for (int c = 0; c < 6; c++) begin
      in_valid[0] = (c == 0 || c == 1 || c == 3);
      in_data[0]  = (c == 0) ? 3'd1 : ((c == 1) ? 3'd2 : 3'd3);
      in_last[0]  = (c == 3);
      in_valid[1] = 1'b1;
      in_data[1]  = held;
      in_last[1]  = 1'b1;
      tick();
      if (c >= 1) begin
        check($sformatf("pkt%0d_valid", c), 32'(out_valid), 32'(lk_vld[c-1]));
        if (lk_vld[c-1]) check($sformatf("pkt%0d_src", c), 32'(out_src), 32'(lk_src[(c-1)*3 +: 3]));
      end
    end
    idle_inputs();
    for (int c = 0; c < 8; c++) tick();

    // Reset while flits are buffered and the output slot is occupied.
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 5'b01000;
      in_data[3] = W'(c + 1);
      in_last[3] = 1'b1;
      tick();
    end
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_ready3", 32'(in_ready[3]), 32'd0);
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 500; c++) begin
      in_valid  = N'($urandom);
      in_data   = (N*W)'($urandom);
      in_last   = N'($urandom) | N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle_inputs();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    check("final_empty_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
